// File: rtl/coax_tx_if.sv
// coax_tx_if: word-load handshake between a producer and the coax transmitter.
//   data  : 10-bit word to send, sampled when load=1 and ready=1
//   load  : single-cycle write strobe
//   ready : holding register empty; a load is accepted only while high
// Modports: master = word producer, slave = coax_tx.
interface coax_tx_if;
  logic [9:0] data;
  logic       load;
  logic       ready;

  modport master (output data, output load, input  ready);
  modport slave  (input  data, input  load, output ready);
endinterface

// File: rtl/coax_tx.sv
// coax_tx: 3270 coax link serial transmitter.
// Accepts 10-bit words through a single-entry holding register and sends each
// frame as: 5 quiesce cells of logical 1, code violation (high 1.5 cells,
// low 1.5 cells), then per word sync(1) + data[9:0] + parity(~^data), then an
// end sequence (one logical-0 cell, tx high 1.5 cells). A word loaded before
// the last PARITY cycle of the current word chains into the same frame.
// Manchester cells: logical 1 = low then high, logical 0 = high then low.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : coax_tx_if.slave (data, load, ready)
//   active       : high for the whole frame
//   tx           : encoded line output, idles low
//   tx_delay     : tx delayed by CLOCKS_PER_BIT/4 clocks (only with COAX_TX_DELAY_EN)
// Optional feature macro: COAX_TX_DELAY_EN.
module coax_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  coax_tx_if.slave bus,
  output logic     active,
  output logic     tx
`ifdef COAX_TX_DELAY_EN
  ,
  output logic     tx_delay
`endif
);

  localparam int unsigned HALF = CLOCKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLOCKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE, QUIESCE, CODE_VIOL, SYNC, DATA, PARITY, END_ZERO, END_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // clock within the current bit cell
  logic [3:0]    cell_q, cell_d;    // cell index within the current state
  logic [9:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic [10:0]   shift_q, shift_d;  // {data[9:0], parity}, MSB on the line

  logic cell_end;
  logic first_half;
  logic leave;

  always_comb begin
    cell_end   = (cnt_q == CW'(CLOCKS_PER_BIT - 1));
    first_half = (cnt_q < CW'(HALF));
    state_d    = state_q;
    cnt_d      = cell_end ? '0 : cnt_q + 1'b1;
    cell_d     = cell_end ? cell_q + 4'd1 : cell_q;
    hold_d     = hold_q;
    full_d     = full_q;
    shift_d    = shift_q;
    leave      = 1'b0;
    tx         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        cell_d = '0;
        if (full_q) state_d = QUIESCE;
      end
      QUIESCE: begin
        tx = ~first_half;
        if (cell_end && cell_q == 4'd4) begin
          state_d = CODE_VIOL;
          leave   = 1'b1;
        end
      end
      CODE_VIOL: begin
        tx = (cell_q == 4'd0) || (cell_q == 4'd1 && first_half);
        if (cell_end && cell_q == 4'd2) begin
          state_d = SYNC;
          leave   = 1'b1;
        end
      end
      SYNC: begin
        tx = ~first_half;
        // Transfer frees the holding register early so the next word can
        // be queued while this one is still on the line.
        if (cnt_q == '0) begin
          shift_d = {hold_q, ~^hold_q};
          full_d  = 1'b0;
        end
        if (cell_end) begin
          state_d = DATA;
          leave   = 1'b1;
        end
      end
      DATA: begin
        tx = first_half ? ~shift_q[10] : shift_q[10];
        if (cell_end) begin
          shift_d = {shift_q[9:0], 1'b0};
          if (cell_q == 4'd9) begin
            state_d = PARITY;
            leave   = 1'b1;
          end
        end
      end
      PARITY: begin
        tx = first_half ? ~shift_q[10] : shift_q[10];
        if (cell_end) begin
          state_d = full_q ? SYNC : END_ZERO;
          leave   = 1'b1;
        end
      end
      END_ZERO: begin
        tx = first_half;
        if (cell_end) begin
          state_d = END_HOLD;
          leave   = 1'b1;
        end
      end
      END_HOLD: begin
        tx = 1'b1;
        if (cell_q == 4'd1 && cnt_q == CW'(HALF - 1)) begin
          state_d = IDLE;
          leave   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (leave) begin
      cnt_d  = '0;
      cell_d = '0;
    end

    if (bus.load && !full_q) begin
      hold_d = bus.data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cell_q  <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cell_q  <= cell_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      shift_q <= shift_d;
    end
  end

  assign bus.ready = ~full_q;
  assign active    = (state_q != IDLE);

`ifdef COAX_TX_DELAY_EN
  localparam int unsigned QTR = CLOCKS_PER_BIT / 4;
  logic [QTR-1:0] dly_q;

  always_ff @(posedge clk) begin
    if (!reset_n) dly_q <= '0;
    else          dly_q <= {dly_q[QTR-2:0], tx};
  end

  assign tx_delay = dly_q[QTR-1];
`endif

endmodule

// File: tb/tb_coax_tx.sv
// tb_coax_tx: randomized self-checking bench for coax_tx. A frame-level model
// turns the list of driven loads into expected per-cycle tx/active/ready.
module tb_coax_tx;
  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int QTR  = CPB / 4;
  localparam int QC   = 8 * CPB;        // quiesce + code violation
  localparam int WL   = 12 * CPB;       // one word: sync + 10 data + parity
  localparam int EL   = (5 * CPB) / 2;  // end zero cell + 1.5 cells high
  localparam int MAXH = 1600;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  coax_tx_if bus_if();
  logic active, tx;
`ifdef COAX_TX_DELAY_EN
  logic tx_delay;
`endif

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .active  (active),
    .tx      (tx)
`ifdef COAX_TX_DELAY_EN
    ,
    .tx_delay(tx_delay)
`endif
  );

  int checks = 0;
  int errors = 0;

  int         sched_c[$];
  logic [9:0] sched_w[$];
  logic [9:0] frame_w[$];

  bit   exp_tx[MAXH], exp_act[MAXH], exp_rdy[MAXH];
  logic got_tx[MAXH], got_act[MAXH], got_rdy[MAXH];
`ifdef COAX_TX_DELAY_EN
  logic got_dly[MAXH];
`endif
  int wp;
  int model_h;

  // ---------------- reference model ----------------
  function automatic void put(bit v, int n);
    for (int i = 0; i < n; i++) begin
      if (wp < model_h) begin
        exp_tx[wp]  = v;
        exp_act[wp] = 1'b1;
      end
      wp++;
    end
  endfunction

  function automatic void put_cell(bit b);
    put(!b, HALF);
    put(b, HALF);
  endfunction

  function automatic void emit_frame(int fs);
    logic [9:0] w;
    wp = fs;
    for (int i = 0; i < 5; i++) put_cell(1'b1);
    put(1'b1, CPB + HALF);
    put(1'b0, CPB + HALF);
    foreach (frame_w[k]) begin
      w = frame_w[k];
      put_cell(1'b1);
      for (int b = 9; b >= 0; b--) put_cell(w[b]);
      put_cell(~^w);
    end
    put_cell(1'b0);
    put(1'b1, CPB + HALF);
  endfunction

  // Loads must be in sched in cycle order. A word loaded in cycle a is held
  // from a+1; its first SYNC cycle w frees the register (ready again at w+1).
  function automatic void build_model(int h, int rst_at);
    int  a_prev = -1, w_prev = -1, w_last = 0, idle_at = 0, fs = 0, c, w;
    bit  open = 1'b0;
    model_h = h;
    for (int i = 0; i < h; i++) begin
      exp_tx[i] = 1'b0; exp_act[i] = 1'b0; exp_rdy[i] = 1'b1;
    end
    frame_w.delete();
    foreach (sched_c[k]) begin
      c = sched_c[k];
      if (c > a_prev && c <= w_prev) continue;   // ready low: ignored
      if (open && c <= w_last + WL - 2) begin
        w = w_last + WL;                          // chained into same frame
      end else begin
        if (open) begin
          emit_frame(fs);
          idle_at = w_last + WL + EL;
        end
        fs = ((idle_at > c + 1) ? idle_at : c + 1) + 1;
        w = fs + QC;
        open = 1'b1;
        frame_w.delete();
      end
      frame_w.push_back(sched_w[k]);
      for (int x = c + 1; x <= w && x < h; x++) exp_rdy[x] = 1'b0;
      a_prev = c; w_prev = w; w_last = w;
    end
    if (open) emit_frame(fs);
    if (rst_at >= 0)
      for (int i = rst_at + 1; i < h; i++) begin
        exp_tx[i] = 1'b0; exp_act[i] = 1'b0; exp_rdy[i] = 1'b1;
      end
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    bus_if.load = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;   // this cycle is scenario cycle 0
  endtask

  task automatic run(int h, int rst_at);
    for (int c = 0; c < h; c++) begin
      bus_if.load = 1'b0;
      bus_if.data = 10'($urandom);
      foreach (sched_c[k])
        if (sched_c[k] == c) begin
          bus_if.load = 1'b1;
          bus_if.data = sched_w[k];
        end
      reset_n = (c == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      got_tx[c]  = tx;
      got_act[c] = active;
      got_rdy[c] = bus_if.ready;
`ifdef COAX_TX_DELAY_EN
      got_dly[c] = tx_delay;
`endif
      @(posedge clk);
      #1;
    end
    bus_if.load = 1'b0;
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus_if.load = 1'b1;
    bus_if.data = 10'($urandom);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b want 0", tx); end
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
      checks++;
      if (bus_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus_if.ready); end
      @(posedge clk);
    end
    bus_if.load = 1'b0;
  endtask

  task automatic test_single();
    logic [9:0] wl[5];
    int h, e;
    wl[0] = 10'h2A5; wl[1] = 10'h000; wl[2] = 10'h3FF;
    wl[3] = 10'($urandom); wl[4] = 10'($urandom);
    h = 230;
    for (int s = 0; s < 5; s++) begin
      do_reset();
      sched_c.delete(); sched_w.delete();
      sched_c.push_back(1 + int'($urandom_range(0, 3)));
      sched_w.push_back(wl[s]);
      build_model(h, -1);
      run(h, -1);
      for (int c = 0; c < h; c++) begin
        checks++;
        if (got_tx[c] !== exp_tx[c]) begin errors++;
          $display("FAIL single_tx w=%h c=%0d: got %b want %b", wl[s], c, got_tx[c], exp_tx[c]); end
        checks++;
        if (got_act[c] !== exp_act[c]) begin errors++;
          $display("FAIL single_active w=%h c=%0d: got %b want %b", wl[s], c, got_act[c], exp_act[c]); end
        checks++;
        if (got_rdy[c] !== exp_rdy[c]) begin errors++;
          $display("FAIL single_ready w=%h c=%0d: got %b want %b", wl[s], c, got_rdy[c], exp_rdy[c]); end
`ifdef COAX_TX_DELAY_EN
        e = (c >= QTR) ? int'(exp_tx[c - QTR]) : 0;
        checks++;
        if (got_dly[c] !== 1'(e)) begin errors++;
          $display("FAIL tx_delay w=%h c=%0d: got %b want %0d", wl[s], c, got_dly[c], e); end
`else
        e = 0;
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    int a0, w0, h;
    h = 520;
    for (int s = 0; s < 4; s++) begin
      do_reset();
      sched_c.delete(); sched_w.delete();
      a0 = 1;
      w0 = a0 + 2 + QC;   // first SYNC cycle of word 0
      sched_c.push_back(a0);
      sched_w.push_back((s == 0) ? 10'h3FF : 10'($urandom));
      case (s)
        0: sched_c.push_back(w0 + int'($urandom_range(1, WL - 2)));
        1: sched_c.push_back(w0 + 1);
        2: sched_c.push_back(w0 + WL - 2);
        default: sched_c.push_back(w0 + int'($urandom_range(1, WL - 2)));
      endcase
      sched_w.push_back((s == 0) ? 10'h155 : 10'($urandom));
      if (s == 3) begin
        sched_c.push_back(w0 + WL + int'($urandom_range(1, WL - 2)));
        sched_w.push_back(10'($urandom));
      end
      build_model(h, -1);
      run(h, -1);
      for (int c = 0; c < h; c++) begin
        checks++;
        if (got_tx[c] !== exp_tx[c]) begin errors++;
          $display("FAIL b2b_tx s=%0d c=%0d: got %b want %b", s, c, got_tx[c], exp_tx[c]); end
        checks++;
        if (got_act[c] !== exp_act[c]) begin errors++;
          $display("FAIL b2b_active s=%0d c=%0d: got %b want %b", s, c, got_act[c], exp_act[c]); end
        checks++;
        if (got_rdy[c] !== exp_rdy[c]) begin errors++;
          $display("FAIL b2b_ready s=%0d c=%0d: got %b want %b", s, c, got_rdy[c], exp_rdy[c]); end
      end
    end
  endtask

  task automatic test_late_load();
    int w0, h;
    h = 420;
    do_reset();
    sched_c.delete(); sched_w.delete();
    w0 = 1 + 2 + QC;
    sched_c.push_back(1);           sched_w.push_back(10'($urandom));
    sched_c.push_back(w0 + WL - 1); sched_w.push_back(10'($urandom));
    build_model(h, -1);
    run(h, -1);
    for (int c = 0; c < h; c++) begin
      checks++;
      if (got_tx[c] !== exp_tx[c]) begin errors++;
        $display("FAIL late_tx c=%0d: got %b want %b", c, got_tx[c], exp_tx[c]); end
      checks++;
      if (got_act[c] !== exp_act[c]) begin errors++;
        $display("FAIL late_active c=%0d: got %b want %b", c, got_act[c], exp_act[c]); end
      checks++;
      if (got_rdy[c] !== exp_rdy[c]) begin errors++;
        $display("FAIL late_ready c=%0d: got %b want %b", c, got_rdy[c], exp_rdy[c]); end
    end
  endtask

  task automatic test_ignored_load();
    int w0, h, x;
    h = 260;
    do_reset();
    sched_c.delete(); sched_w.delete();
    w0 = 1 + 2 + QC;
    x = int'($urandom_range(2, w0 - 1));
    sched_c.push_back(1);  sched_w.push_back(10'($urandom));
    sched_c.push_back(x);  sched_w.push_back(10'($urandom));
    sched_c.push_back(w0); sched_w.push_back(10'($urandom));
    build_model(h, -1);
    run(h, -1);
    for (int c = 0; c < h; c++) begin
      checks++;
      if (got_tx[c] !== exp_tx[c]) begin errors++;
        $display("FAIL ignored_tx c=%0d: got %b want %b", c, got_tx[c], exp_tx[c]); end
      checks++;
      if (got_act[c] !== exp_act[c]) begin errors++;
        $display("FAIL ignored_active c=%0d: got %b want %b", c, got_act[c], exp_act[c]); end
      checks++;
      if (got_rdy[c] !== exp_rdy[c]) begin errors++;
        $display("FAIL ignored_ready c=%0d: got %b want %b", c, got_rdy[c], exp_rdy[c]); end
    end
  endtask

  task automatic test_mid_reset();
    int w0, h, r;
    do_reset();
    sched_c.delete(); sched_w.delete();
    w0 = 1 + 2 + QC;
    r = w0 + CPB + int'($urandom_range(0, 10 * CPB - 1));   // inside DATA
    h = r + 220;
    sched_c.push_back(1); sched_w.push_back(10'h1C3);
    build_model(h, r);
    run(h, r);
    for (int c = 0; c < h; c++) begin
      checks++;
      if (got_tx[c] !== exp_tx[c]) begin errors++;
        $display("FAIL midrst_tx c=%0d: got %b want %b", c, got_tx[c], exp_tx[c]); end
      checks++;
      if (got_act[c] !== exp_act[c]) begin errors++;
        $display("FAIL midrst_active c=%0d: got %b want %b", c, got_act[c], exp_act[c]); end
      checks++;
      if (got_rdy[c] !== exp_rdy[c]) begin errors++;
        $display("FAIL midrst_ready c=%0d: got %b want %b", c, got_rdy[c], exp_rdy[c]); end
    end
  endtask

  initial begin
    bus_if.load = 1'b0;
    bus_if.data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_late_load();
    test_ignored_load();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
